// File: rtl/ctxt_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ctxt_pkg
// Description : Shared FSM state encoding, default flow-control message and
//               a one-hot to index helper for the context event scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ctxt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRIG      = 2'd1,
    ST_WAIT_SENT = 2'd2
  } state_t;

  localparam logic [31:0] FC_MSG_DEFAULT = 32'h0000_0008;

  // Index of the set bit of a one-hot vector (up to 8 sources); 0 if none set.
  function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) r = 3'(i);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctxt_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ctxt_rr_arb
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting one above the last grant, with wrap, and
//               returns a one-hot grant (all zero when nothing requests).
// Revision    : 1.0 - initial release
// ============================================================================
module ctxt_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] sel;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    sel   = '0;
    for (int off = N; off >= 1; off--) begin
      sel = IW'((int'(last_grant) + off) % N);
      if (req[sel]) begin
        grant      = '0;
        grant[sel] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctxt_event_sched.sv
`default_nettype none
// ============================================================================
// Module      : ctxt_event_sched
// Description : Collects per-source event pulses, holds one pending message
//               per source, and issues them round-robin to a context-packet
//               generator with a trigger/sent handshake. Periodic flow-control
//               packets fill in when no source is pending.
//               Optional macro CTXT_WATCHDOG_EN adds a WAIT_SENT watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ctxt_event_sched
  import ctxt_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] FC_MSG    = FC_MSG_DEFAULT,
  parameter int          WD_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [NUM_SRC-1:0]     evt_req,
  input  logic [32*NUM_SRC-1:0]  evt_msg,
  input  logic [15:0]            fc_period,
  output logic                   trigger,
  output logic [31:0]            message,
  input  logic                   sent,
  output logic                   busy,
  output logic [15:0]            drop_cnt,
  output logic                   wd_err
);

  localparam int IDXW = $clog2(NUM_SRC);

  state_t              state;
  logic [NUM_SRC-1:0]  pending;
  logic [NUM_SRC-1:0]  grant;
  logic [NUM_SRC-1:0]  take_mask;
  logic [NUM_SRC-1:0]  pend_kept;
  logic [NUM_SRC-1:0]  drops;
  logic [IDXW-1:0]     last_grant;
  logic [IDXW-1:0]     grant_idx;
  logic [31:0]         stored [NUM_SRC];
  logic                fc_pending;
  logic [15:0]         fc_cnt;
  logic                fc_hit;
  logic                take_src;
  logic                take_fc;
  logic [3:0]          drop_num;
  logic [16:0]         drop_sum;

  ctxt_rr_arb #(.N(NUM_SRC)) u_arb (
    .req        (pending),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign grant_idx = IDXW'(onehot_idx(8'(grant)));

  // A grant is only taken from IDLE; a soft clear suppresses it that cycle.
  assign take_src  = (state == ST_IDLE) && !clear && (|pending);
  assign take_fc   = (state == ST_IDLE) && !clear && !(|pending) && fc_pending;
  assign take_mask = take_src ? grant : '0;
  // A re-request in the grant cycle lands on a freshly freed slot, not a drop.
  assign pend_kept = pending & ~take_mask;
  assign drops     = evt_req & pend_kept;
  assign fc_hit    = (fc_period != 16'd0) && (fc_cnt == fc_period - 16'd1);

  // Count simultaneous drops and saturate the running total.
  always_comb begin
    drop_num = 4'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      drop_num = drop_num + 4'(drops[i]);
    end
    drop_sum = {1'b0, drop_cnt} + 17'(drop_num);
  end

`ifdef CTXT_WATCHDOG_EN
  localparam int WDW = $clog2(WD_CYCLES + 1);
  logic [WDW-1:0] wd_cnt;
`else
  assign wd_err = 1'b0;
`endif

  // Handshake FSM with registered trigger, message and busy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      trigger    <= 1'b0;
      message    <= '0;
      busy       <= 1'b0;
      last_grant <= IDXW'(NUM_SRC - 1);
`ifdef CTXT_WATCHDOG_EN
      wd_cnt     <= '0;
      wd_err     <= 1'b0;
`endif
    end else begin
      trigger <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take_src) begin
            state      <= ST_TRIG;
            trigger    <= 1'b1;
            busy       <= 1'b1;
            message    <= stored[grant_idx];
            last_grant <= grant_idx;
          end else if (take_fc) begin
            state   <= ST_TRIG;
            trigger <= 1'b1;
            busy    <= 1'b1;
            message <= FC_MSG;
          end
        end
        ST_TRIG: begin
`ifdef CTXT_WATCHDOG_EN
          wd_cnt <= '0;
`endif
          if (clear) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= ST_WAIT_SENT;
          end
        end
        ST_WAIT_SENT: begin
          // A packet in flight is always allowed to finish, even across clear.
          if (sent) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
`ifdef CTXT_WATCHDOG_EN
          else if (wd_cnt == WDW'(WD_CYCLES - 1)) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            wd_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
`ifdef CTXT_WATCHDOG_EN
      if (clear) wd_err <= 1'b0;
`endif
    end
  end

  // Pending slots, stored messages, drop counter and flow-control timer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      fc_pending <= 1'b0;
      fc_cnt     <= '0;
      drop_cnt   <= '0;
      for (int i = 0; i < NUM_SRC; i++) stored[i] <= '0;
    end else if (clear) begin
      pending    <= '0;
      fc_pending <= 1'b0;
      fc_cnt     <= '0;
      drop_cnt   <= '0;
    end else begin
      pending <= pend_kept | evt_req;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (evt_req[i] && !pend_kept[i]) stored[i] <= evt_msg[32*i +: 32];
      end
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (trigger || fc_hit) fc_cnt <= '0;
      else                   fc_cnt <= fc_cnt + 16'd1;
      if (fc_hit && !trigger) fc_pending <= 1'b1;
      else if (take_fc)       fc_pending <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: doc/ctxt_event_sched.md
CTXT_EVENT_SCHED -- requirements
Module: ctxt_event_sched

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of event sources (2..8).
REQ-002 SHALL have parameter FC_MSG, default 32'h0000_0008: message word used for periodic flow-control packets.
REQ-003 SHALL have parameter WD_CYCLES, default 1024: sent-watchdog limit, used only with CTXT_WATCHDOG_EN.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  input  1  synchronous soft clear.
REQ-007 SHALL have port evt_req  input  NUM_SRC  per-source one-cycle event pulses.
REQ-008 SHALL have port evt_msg  input  32*NUM_SRC  per-source message words; source i occupies bits [32i+31:32i].
REQ-009 SHALL have port fc_period  input  16  flow-control packet period in cycles; 0 disables periodic packets.
REQ-010 SHALL have port trigger  output  1  one-cycle request to the context-packet generator.
REQ-011 SHALL have port message  output  32  message word, stable from the trigger cycle until sent.
REQ-012 SHALL have port sent  input  1  one-cycle pulse from the generator when the packet is complete.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port drop_cnt  output  16  count of events lost to an already-pending source; saturates at 16'hFFFF.
REQ-015 SHALL have port wd_err  output  1  sticky watchdog-expiry flag.

Function
REQ-016 SHALL keep one pending bit and one 32-bit stored message per source; evt_req[i] with pending[i]=0 sets pending[i] and stores evt_msg slice i.
REQ-017 SHALL, on evt_req[i] with pending[i]=1, keep the first stored message and increment drop_cnt.
REQ-018 SHALL implement FSM states IDLE, TRIG and WAIT_SENT.
REQ-019 SHALL, in IDLE with any pending bit or fc_pending set, move to TRIG on the next edge, latching the grant and message and clearing the granted pending bit.
REQ-020 SHALL grant sources round-robin, searching from last_grant+1 with wrap; fc_pending is granted only when no source is pending.
REQ-021 SHALL assert trigger exactly in the TRIG cycle, then move to WAIT_SENT.
REQ-022 SHALL leave WAIT_SENT for IDLE on the edge where sent=1.
REQ-023 SHALL give an evt_req in cycle N a trigger in cycle N+2 when the block is IDLE with nothing pending.
REQ-024 SHALL give set priority when a source is re-requested in the same cycle its pending bit is cleared by grant.
REQ-025 SHALL run fc_cnt, which clears on each trigger; when fc_period!=0 and fc_cnt==fc_period-1, it sets fc_pending and clears fc_cnt.
REQ-026 SHALL, on clear, zero pending bits, fc_pending, fc_cnt and drop_cnt, and return TRIG to IDLE; WAIT_SENT still completes, so the generator is never left with a half packet.

Reset
REQ-027 SHALL, on reset_n low, asynchronously set state IDLE, trigger 0, message 0, busy 0, drop_cnt 0, wd_err 0, all pending bits 0, fc_cnt 0 and last_grant NUM_SRC-1.
REQ-028 SHALL, when reset is asserted mid-packet, abandon the packet with no trigger replay after release.

Configuration
REQ-029 SHALL, with CTXT_WATCHDOG_EN defined, count cycles in WAIT_SENT; on reaching WD_CYCLES without sent, go to IDLE and set wd_err until reset or clear.
REQ-030 SHALL, without CTXT_WATCHDOG_EN, wait in WAIT_SENT indefinitely, tie wd_err to 0 and instantiate no watchdog counter.

Structure
REQ-031 SHALL place the FSM state encoding and the FC_MSG default in shared package ctxt_pkg.
REQ-032 SHALL implement the round-robin priority search as sub-module ctxt_rr_arb (request vector and last grant in, one-hot grant out, combinational).

Verification
REQ-033 SHALL cover a single event: evt_req[2] with msg 32'h0000_0002 in cycle 10 -> trigger in cycle 12 with message 32'h0000_0002; busy until the edge after sent.
REQ-034 SHALL cover round-robin order: evt_req=4'b1111 in one cycle with sent returned 3 cycles after each trigger -> grant order 0,1,2,3, four triggers.
REQ-035 SHALL cover drops: two evt_req[1] pulses (msgs A then B) while source 1 is pending -> message A sent, drop_cnt=1.
REQ-036 SHALL cover periodic flow control: fc_period=100 with no events -> trigger every 100+latency cycles with message FC_MSG; fc_period=0 -> no triggers.
REQ-037 SHALL cover the watchdog: with CTXT_WATCHDOG_EN and sent never asserted -> IDLE after 1024 WAIT_SENT cycles, wd_err=1; without the macro, still in WAIT_SENT after 5000 cycles.
REQ-038 SHALL cover clear and reset: clear in WAIT_SENT -> stays until sent, pending empty afterwards; reset_n low in TRIG -> outputs at reset values immediately.
